pulse_channel1: RTL and testbench



---
 rtl/gb_sound_pkg.sv | 40 ++++
 rtl/gb_envelope.sv | 51 +++++
 rtl/pulse_channel1.sv | 167 ++++++++++++++++
 tb/tb_pulse_channel1.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_sound_pkg.sv
// Shared constants and helpers for the Game Boy-style sound channels:
// duty table, field widths, timer reload and sweep arithmetic.
package gb_sound_pkg;

  localparam int unsigned CLK_HZ  = 4194304;
  localparam int          FREQ_W  = 11;
  localparam int          VOL_W   = 4;
  localparam int          LEN_MAX = 64;

  // Leftmost bit of each pattern is step 0.
  localparam logic [7:0] DUTY_TABLE [4] = '{
    8'b00000001,
    8'b10000001,
    8'b10000111,
    8'b01111110
  };

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pat;
    pat = DUTY_TABLE[duty];
    return pat[3'd7 - step];
  endfunction

  // (2048 - f) * 4 - 1 == {2047 - f, 2'b11} == {~f, 2'b11}
  function automatic logic [12:0] ftimer_reload(input logic [FREQ_W-1:0] f);
    return {~f, 2'b11};
  endfunction

  // 12-bit result; bit 11 set means the add path went past 2047.
  function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] base,
                                                 input logic [2:0]        sh,
                                                 input logic              neg);
    logic [FREQ_W:0] b;
    logic [FREQ_W:0] d;
    b = {1'b0, base};
    d = b >> sh;
    return neg ? (b - d) : (b + d);
  endfunction

endpackage

// File: rtl/gb_envelope.sv
// Volume envelope: loads the start volume on a note trigger and steps it
// up or down by one on every expiry of the period timer, saturating at 0/15.
module gb_envelope
  import gb_sound_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             tick,
  input  logic [VOL_W-1:0] start_vol,
  input  logic [2:0]       period,
  input  logic             env_add,
  output logic [VOL_W-1:0] vol
);

  logic [2:0]       env_tmr;
  logic [2:0]       env_tmr_n;
  logic [VOL_W-1:0] vol_n;

  always_comb begin
    vol_n     = vol;
    env_tmr_n = env_tmr;
    if (load) begin
      vol_n     = start_vol;
      env_tmr_n = period;
    end else if (tick && (period != 3'd0)) begin
      // Timer value 1 (or a stale 0) is the last count before expiry.
      if (env_tmr <= 3'd1) begin
        env_tmr_n = period;
        if (env_add && (vol != '1)) begin
          vol_n = vol + VOL_W'(1);
        end else if (!env_add && (vol != '0)) begin
          vol_n = vol - VOL_W'(1);
        end
      end else begin
        env_tmr_n = env_tmr - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vol     <= '0;
      env_tmr <= '0;
    end else begin
      vol     <= vol_n;
      env_tmr <= env_tmr_n;
    end
  end

endmodule

// File: rtl/pulse_channel1.sv
// Square-wave channel 1: frequency timer and duty sequencer, sweep unit,
// length counter and envelope, producing a registered 4-bit amplitude.
module pulse_channel1
  import gb_sound_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk256,
  input  logic              clk128,
  input  logic              clk64,
  input  logic [2:0]        swpPd,
  input  logic              negate,
  input  logic [2:0]        shift,
  input  logic [FREQ_W-1:0] freq,
  input  logic [5:0]        lenLoad,
  input  logic [1:0]        duty,
  input  logic [VOL_W-1:0]  startVol,
  input  logic [2:0]        period,
  input  logic              trigger,
  input  logic              lenEnable,
  input  logic              envAdd,
  output logic [VOL_W-1:0]  out
);

  logic              en;
  logic [6:0]        len_cnt;
  logic [FREQ_W-1:0] freq_reg;
  logic [FREQ_W-1:0] shadow;
  logic [3:0]        sweep_tmr;
  logic              sweep_en;
  logic [12:0]       ftimer;
  logic [2:0]        step;
  logic              trig_d;
  logic [FREQ_W-1:0] freq_d;

  logic              en_n;
  logic [6:0]        len_n;
  logic [FREQ_W-1:0] freq_reg_n;
  logic [FREQ_W-1:0] shadow_n;
  logic [3:0]        sweep_tmr_n;
  logic              sweep_en_n;
  logic [12:0]       ftimer_n;
  logic [2:0]        step_n;

  logic              dac_on;
  logic              trig_rise;
  logic [3:0]        sweep_reload;
  logic [FREQ_W:0]   trig_new;
  logic [FREQ_W:0]   sweep_new;
  logic [FREQ_W:0]   sweep_new2;
  logic [VOL_W-1:0]  vol;

  assign dac_on       = (startVol != '0) || envAdd;
  assign trig_rise    = trigger && !trig_d;
  assign sweep_reload = (swpPd == 3'd0) ? 4'd8 : {1'b0, swpPd};

  gb_envelope u_env (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (trig_rise),
    .tick      (clk64),
    .start_vol (startVol),
    .period    (period),
    .env_add   (envAdd),
    .vol       (vol)
  );

  always_comb begin
    en_n        = en;
    len_n       = len_cnt;
    freq_reg_n  = freq_reg;
    shadow_n    = shadow;
    sweep_tmr_n = sweep_tmr;
    sweep_en_n  = sweep_en;
    ftimer_n    = ftimer - 13'd1;
    step_n      = step;
    trig_new    = '0;
    sweep_new   = '0;
    sweep_new2  = '0;

    if (ftimer == 13'd0) begin
      ftimer_n = ftimer_reload(freq_reg);
      step_n   = step + 3'd1;
    end

    if (freq != freq_d) begin
      freq_reg_n = freq;
    end

    if (trig_rise) begin
      // A trigger owns the cycle: frame ticks arriving with it are dropped.
      en_n        = 1'b1;
      len_n       = 7'(LEN_MAX) - {1'b0, lenLoad};
      freq_reg_n  = freq;
      shadow_n    = freq;
      ftimer_n    = ftimer_reload(freq);
      sweep_tmr_n = sweep_reload;
      sweep_en_n  = (swpPd != 3'd0) || (shift != 3'd0);
      trig_new    = sweep_calc(freq, shift, negate);
      if ((shift != 3'd0) && (trig_new > 12'd2047)) begin
        en_n = 1'b0;
      end
    end else begin
      if (clk256 && lenEnable && (len_cnt != 7'd0)) begin
        len_n = len_cnt - 7'd1;
        if (len_n == 7'd0) begin
          en_n = 1'b0;
        end
      end

      if (clk128) begin
        if (sweep_tmr <= 4'd1) begin
          sweep_tmr_n = sweep_reload;
          if (sweep_en && (swpPd != 3'd0)) begin
            sweep_new = sweep_calc(shadow, shift, negate);
            if (sweep_new > 12'd2047) begin
              en_n = 1'b0;
            end else if (shift != 3'd0) begin
              shadow_n   = sweep_new[FREQ_W-1:0];
              freq_reg_n = sweep_new[FREQ_W-1:0];
              // Look one sweep ahead so an upcoming overflow silences now.
              sweep_new2 = sweep_calc(sweep_new[FREQ_W-1:0], shift, negate);
              if (sweep_new2 > 12'd2047) begin
                en_n = 1'b0;
              end
            end
          end
        end else begin
          sweep_tmr_n = sweep_tmr - 4'd1;
        end
      end
    end

    if (!dac_on) begin
      en_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      len_cnt   <= '0;
      freq_reg  <= '0;
      shadow    <= '0;
      sweep_tmr <= '0;
      sweep_en  <= 1'b0;
      ftimer    <= '0;
      step      <= '0;
      trig_d    <= 1'b0;
      freq_d    <= '0;
      out       <= '0;
    end else begin
      en        <= en_n;
      len_cnt   <= len_n;
      freq_reg  <= freq_reg_n;
      shadow    <= shadow_n;
      sweep_tmr <= sweep_tmr_n;
      sweep_en  <= sweep_en_n;
      ftimer    <= ftimer_n;
      step      <= step_n;
      trig_d    <= trigger;
      freq_d    <= freq;
      out       <= (en && duty_bit(duty, step)) ? vol : '0;
    end
  end

endmodule

// File: tb/tb_pulse_channel1.sv
// Bench for pulse_channel1: tone run lengths, duty shapes, length, envelope,
// sweep, DAC gating and async reset, checked against a queued scoreboard.
module tb_pulse_channel1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk256 = 1'b0;
  logic        clk128 = 1'b0;
  logic        clk64 = 1'b0;
  logic [2:0]  swpPd = '0;
  logic        negate = 1'b0;
  logic [2:0]  shift = '0;
  logic [10:0] freq = '0;
  logic [5:0]  lenLoad = '0;
  logic [1:0]  duty = '0;
  logic [3:0]  startVol = '0;
  logic [2:0]  period = '0;
  logic        trigger = 1'b0;
  logic        lenEnable = 1'b0;
  logic        envAdd = 1'b0;
  logic [3:0]  out;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q[$];
  logic [15:0] hi_q[$];
  logic [15:0] lo_q[$];
  int          run_window = 0;

  pulse_channel1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk256    (clk256),
    .clk128    (clk128),
    .clk64     (clk64),
    .swpPd     (swpPd),
    .negate    (negate),
    .shift     (shift),
    .freq      (freq),
    .lenLoad   (lenLoad),
    .duty      (duty),
    .startVol  (startVol),
    .period    (period),
    .trigger   (trigger),
    .lenEnable (lenEnable),
    .envAdd    (envAdd),
    .out       (out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_note(input logic [10:0] f, input logic [1:0] d, input logic [3:0] v,
                          input logic [2:0] p, input logic up);
    @(negedge clk);
    freq = f; duty = d; startVol = v; period = p; envAdd = up;
  endtask

  task automatic set_sweep(input logic [2:0] pd, input logic [2:0] sh, input logic neg);
    @(negedge clk);
    swpPd = pd; shift = sh; negate = neg;
  endtask

  task automatic set_len(input logic [5:0] ld, input logic le);
    @(negedge clk);
    lenLoad = ld; lenEnable = le;
  endtask

  // One-cycle strobes (and/or a trigger rising edge) seen by a single posedge.
  task automatic fire(input logic s256, input logic s128, input logic s64, input logic trig);
    @(negedge clk);
    clk256 = s256; clk128 = s128; clk64 = s64; trigger = trig;
    @(negedge clk);
    clk256 = 1'b0; clk128 = 1'b0; clk64 = 1'b0; trigger = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_peak(input int v);
    exp_q.push_back(16'(v));
  endtask

  task automatic check_peak(input string tag, input int window);
    logic [3:0] pk;
    int e;
    pk = '0;
    cycles(2);
    repeat (window) begin
      @(negedge clk);
      if (out > pk) pk = out;
    end
    e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
    check_eq(tag, int'(pk), e);
  endtask

  task automatic expect_runs(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      hi_q.push_back(16'(hi));
      lo_q.push_back(16'(lo));
    end
    run_window = 2 * ((hi > lo) ? hi : lo) + n * (hi + lo) + 8;
  endtask

  // The run in progress and the one straddling the trigger are skipped.
  task automatic check_runs(input string tag, input logic [3:0] amp);
    logic       cur;
    logic       lvl;
    logic [3:0] run_amp;
    int         cnt;
    int         skip;
    @(negedge clk);
    cur = (out != '0); run_amp = out; cnt = 1; skip = 2;
    repeat (run_window) begin
      @(negedge clk);
      lvl = (out != '0);
      if (lvl != cur) begin
        if (skip > 0) begin
          skip--;
        end else if (cur && (hi_q.size() > 0)) begin
          check_eq({tag, "_hi"}, cnt, int'(hi_q.pop_front()));
          check_eq({tag, "_amp"}, int'(run_amp), int'(amp));
        end else if (!cur && (lo_q.size() > 0)) begin
          check_eq({tag, "_lo"}, cnt, int'(lo_q.pop_front()));
        end
        cur = lvl; cnt = 1; run_amp = out;
      end else begin
        cnt++;
      end
    end
    check_eq({tag, "_left"}, hi_q.size() + lo_q.size(), 0);
    hi_q.delete();
    lo_q.delete();
  endtask

  // ---------------- stimulus ----------------
  int duty_hi[4] = '{4, 8, 16, 24};
  int duty_lo[4] = '{28, 24, 16, 8};

  initial begin
    int waited;

    cycles(3);
    check_eq("reset_out", int'(out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // 512 Hz tone, 50% duty
    set_note(11'd1792, 2'b10, 4'd15, 3'd0, 1'b0);
    fire(0, 0, 0, 1);
    expect_runs(4096, 4096, 1);
    check_runs("tone512", 4'd15);

    // Duty shapes at the fastest frequency (4-cycle step)
    for (int d = 0; d < 4; d++) begin
      set_note(11'd2047, 2'(d), 4'd9, 3'd0, 1'b0);
      fire(0, 0, 0, 1);
      expect_runs(duty_hi[d], duty_lo[d], 2);
      check_runs($sformatf("duty%0d", d), 4'd9);
    end

    // Length counter
    set_note(11'd2047, 2'b10, 4'd15, 3'd0, 1'b0);
    set_len(6'd62, 1'b1);
    fire(0, 0, 0, 1);
    expect_peak(15); check_peak("len_start", 40);
    fire(1, 0, 0, 0);
    expect_peak(15); check_peak("len_tick1", 40);
    fire(1, 0, 0, 0);
    expect_peak(0);  check_peak("len_expire", 40);
    set_len(6'd62, 1'b0);
    fire(0, 0, 0, 1);
    repeat (4) fire(1, 0, 0, 0);
    expect_peak(15); check_peak("len_disabled", 40);

    set_len(6'd0, 1'b1);
    fire(0, 0, 0, 1);
    repeat (63) fire(1, 0, 0, 0);
    expect_peak(15); check_peak("len64_63", 40);
    fire(1, 0, 0, 0);
    expect_peak(0);  check_peak("len64_64", 40);

    set_len(6'd63, 1'b1);
    fire(0, 0, 0, 1);
    fire(1, 0, 0, 1);
    expect_peak(15); check_peak("trig_beats_len", 40);
    fire(1, 0, 0, 0);
    expect_peak(0);  check_peak("len1_expire", 40);

    // Simultaneous length and envelope ticks
    set_note(11'd2047, 2'b11, 4'd3, 3'd1, 1'b0);
    set_len(6'd62, 1'b1);
    fire(0, 0, 0, 1);
    expect_peak(3); check_peak("simul_start", 40);
    fire(1, 0, 1, 0);
    expect_peak(2); check_peak("simul_both", 40);
    fire(1, 0, 0, 0);
    expect_peak(0); check_peak("simul_len_off", 40);
    set_len(6'd0, 1'b0);

    // Envelope down, saturating at 0
    fire(0, 0, 0, 1);
    expect_peak(3); check_peak("envdn_3", 40);
    fire(0, 0, 1, 0); expect_peak(2); check_peak("envdn_2", 40);
    fire(0, 0, 1, 0); expect_peak(1); check_peak("envdn_1", 40);
    fire(0, 0, 1, 0); expect_peak(0); check_peak("envdn_0", 40);
    fire(0, 0, 1, 0); expect_peak(0); check_peak("envdn_sat", 40);
    fire(0, 0, 1, 1); expect_peak(3); check_peak("trig_beats_env", 40);

    // Envelope up, saturating at 15
    set_note(11'd2047, 2'b11, 4'd14, 3'd1, 1'b1);
    fire(0, 0, 0, 1);
    expect_peak(14); check_peak("envup_14", 40);
    fire(0, 0, 1, 0); expect_peak(15); check_peak("envup_15", 40);
    fire(0, 0, 1, 0); expect_peak(15); check_peak("envup_sat", 40);

    // Envelope period 2 and period 0
    set_note(11'd2047, 2'b11, 4'd10, 3'd2, 1'b0);
    fire(0, 0, 0, 1);
    fire(0, 0, 1, 0); expect_peak(10); check_peak("envp2_first", 40);
    fire(0, 0, 1, 0); expect_peak(9);  check_peak("envp2_second", 40);
    set_note(11'd2047, 2'b11, 4'd7, 3'd0, 1'b0);
    fire(0, 0, 0, 1);
    fire(0, 0, 1, 0); expect_peak(7); check_peak("envp0_hold", 40);

    // DAC gating
    set_note(11'd2047, 2'b11, 4'd0, 3'd0, 1'b0);
    fire(0, 0, 0, 1);
    expect_peak(0); check_peak("dac_off", 40);
    set_note(11'd2047, 2'b11, 4'd0, 3'd1, 1'b1);
    fire(0, 0, 0, 1);
    expect_peak(0); check_peak("dac_on_vol0", 40);
    fire(0, 0, 1, 0);
    expect_peak(1); check_peak("dac_on_up1", 40);
    set_note(11'd2047, 2'b11, 4'd15, 3'd0, 1'b0);
    fire(0, 0, 0, 1);
    expect_peak(15); check_peak("dac_tone", 40);
    set_note(11'd2047, 2'b11, 4'd0, 3'd0, 1'b0);
    expect_peak(0); check_peak("dac_cut", 40);
    set_note(11'd2047, 2'b11, 4'd15, 3'd0, 1'b0);
    expect_peak(0); check_peak("dac_no_restart", 40);

    // Sweep up: 1980 -> 2010, then look-ahead overflow silences
    set_note(11'd1980, 2'b10, 4'd15, 3'd0, 1'b0);
    set_sweep(3'd1, 3'd6, 1'b0);
    fire(0, 0, 0, 1);
    expect_runs(1088, 1088, 1);
    check_runs("swup_pre", 4'd15);
    fire(0, 1, 0, 0);
    expect_runs(608, 608, 2);
    check_runs("swup_2010", 4'd15);
    fire(0, 1, 0, 0);
    expect_peak(0); check_peak("swup_overflow", 240);

    // Sweep down with period 2: 2040 -> 2025 on the second tick
    set_note(11'd2040, 2'b10, 4'd15, 3'd0, 1'b0);
    set_sweep(3'd2, 3'd7, 1'b1);
    fire(0, 0, 0, 1);
    expect_runs(128, 128, 1);
    check_runs("swdn_pre", 4'd15);
    fire(0, 1, 0, 0);
    expect_runs(128, 128, 1);
    check_runs("swdn_tick1", 4'd15);
    fire(0, 1, 0, 0);
    expect_runs(368, 368, 2);
    check_runs("swdn_2025", 4'd15);

    // Overflow check at trigger time
    set_note(11'd2000, 2'b10, 4'd15, 3'd0, 1'b0);
    set_sweep(3'd0, 3'd1, 1'b0);
    fire(0, 0, 0, 1);
    expect_peak(0); check_peak("trig_ovf_add", 1600);
    set_sweep(3'd0, 3'd1, 1'b1);
    fire(0, 0, 0, 1);
    expect_peak(15); check_peak("trig_sub_ok", 1600);

    // 1024, shift 1, period 1: silent by the second sweep tick
    set_note(11'd1024, 2'b11, 4'd15, 3'd0, 1'b0);
    set_sweep(3'd1, 3'd1, 1'b0);
    fire(0, 0, 0, 1);
    expect_peak(15); check_peak("sw1024_start", 8200);
    fire(0, 1, 0, 0);
    fire(0, 1, 0, 0);
    expect_peak(0); check_peak("sw1024_off", 8200);
    set_sweep(3'd0, 3'd0, 1'b0);

    // Asynchronous reset mid-tone
    set_note(11'd2047, 2'b11, 4'd15, 3'd0, 1'b0);
    fire(0, 0, 0, 1);
    waited = 0;
    while ((out != 4'd15) && (waited < 64)) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rst_pre_tone", int'(out), 15);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_async", int'(out), 0);
    cycles(3);
    check_eq("rst_hold", int'(out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    check_eq("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
